// File: rtl/mipsfpga_ahb_tone_gen.sv
// mipsfpga_ahb_tone_gen: multi-channel square-wave buzzer with timed notes,
// sticky done flags and a single-cycle completion interrupt.
module mipsfpga_ahb_tone_gen #(
    parameter int NUM_CH     = 4,
    parameter int HP_W       = 20,
    parameter int DUR_W      = 16,
    parameter int CLK_PER_US = 50,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [1:0]        wr_addr,
    input  logic [31:0]       wr_data,
    output logic [NUM_CH-1:0] buzz_ch,
    output logic              buzz,
    output logic [NUM_CH-1:0] done,
    output logic              irq
);
    typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;
    localparam int PW = $clog2(CLK_PER_US);

    logic [PW-1:0]     r_presc;
    state_t            r_state [NUM_CH];
    logic [HP_W-1:0]   r_hp    [NUM_CH];
    logic [HP_W-1:0]   r_pcnt  [NUM_CH];
    logic [DUR_W-1:0]  r_dur   [NUM_CH];
    logic [DUR_W-1:0]  r_mscnt [NUM_CH];
    logic [9:0]        r_uscnt [NUM_CH];
    logic [NUM_CH-1:0] r_en, r_buzz_ch, r_done;
    logic              r_buzz, r_irq;
    logic              w_us_tick;
    logic [NUM_CH-1:0] w_sel, w_reload, w_clr, w_run, w_tog, w_ms_wrap, w_expire;

    assign w_us_tick = r_presc == PW'(CLK_PER_US - 1);
    assign buzz_ch   = r_buzz_ch;
    assign buzz      = r_buzz;
    assign done      = r_done;
    assign irq       = r_irq;

    // A reloading write masks the channel's tick/expiry for that cycle.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_sel[i]     = wr_en && wr_ch == CH_W'(i) && wr_addr != 2'd3;
            w_reload[i]  = w_sel[i] && (wr_addr != 2'd2 || wr_data[1]);
            w_clr[i]     = w_sel[i] && wr_addr == 2'd2 && wr_data[2];
            w_run[i]     = !w_reload[i] && r_state[i] == PLAY && r_en[i] && r_hp[i] != '0;
            w_tog[i]     = w_run[i] && w_us_tick && r_pcnt[i] == r_hp[i] - HP_W'(1);
            w_ms_wrap[i] = w_run[i] && w_us_tick && r_dur[i] != '0 && r_uscnt[i] == 10'd999;
            w_expire[i]  = w_ms_wrap[i] && r_mscnt[i] == r_dur[i] - DUR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_presc   <= '0;
            r_en      <= '0;
            r_buzz_ch <= '0;
            r_done    <= '0;
            r_buzz    <= 1'b0;
            r_irq     <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i] <= IDLE;
                r_hp[i]    <= '0;
                r_dur[i]   <= '0;
                r_pcnt[i]  <= '0;
                r_uscnt[i] <= '0;
                r_mscnt[i] <= '0;
            end
        end else begin
            r_presc <= w_us_tick ? '0 : r_presc + PW'(1);
            r_buzz  <= |r_buzz_ch;
            r_irq   <= |w_expire;
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_sel[i] && wr_addr == 2'd0) r_hp[i] <= wr_data[HP_W-1:0];
                if (w_sel[i] && wr_addr == 2'd1) r_dur[i] <= wr_data[DUR_W-1:0];
                if (w_sel[i] && wr_addr == 2'd2) r_en[i] <= wr_data[0];
                if (w_reload[i] || w_expire[i]) begin
                    r_state[i]   <= w_expire[i] ? DONE : IDLE;
                    r_done[i]    <= w_expire[i];
                    r_buzz_ch[i] <= 1'b0;
                    r_pcnt[i]    <= '0;
                    r_uscnt[i]   <= '0;
                    r_mscnt[i]   <= '0;
                end else begin
                    if (w_clr[i]) r_done[i] <= 1'b0;
                    case (r_state[i])
                        IDLE: begin
                            r_buzz_ch[i] <= 1'b0;
                            if (r_en[i] && r_hp[i] != '0) r_state[i] <= PLAY;
                        end
                        PLAY: begin
                            if (!w_run[i]) begin
                                r_state[i]   <= IDLE;
                                r_buzz_ch[i] <= 1'b0;
                                r_pcnt[i]    <= '0;
                                r_uscnt[i]   <= '0;
                                r_mscnt[i]   <= '0;
                            end else if (w_us_tick) begin
                                r_pcnt[i] <= w_tog[i] ? '0 : r_pcnt[i] + HP_W'(1);
                                if (w_tog[i]) r_buzz_ch[i] <= !r_buzz_ch[i];
                                if (r_dur[i] != '0) r_uscnt[i] <= w_ms_wrap[i] ? '0 : r_uscnt[i] + 10'd1;
                                if (w_ms_wrap[i]) r_mscnt[i] <= r_mscnt[i] + DUR_W'(1);
                            end
                        end
                        default: begin
                            r_buzz_ch[i] <= 1'b0;
                            if (!r_en[i]) r_state[i] <= IDLE;
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_mipsfpga_ahb_tone_gen.sv
// tb_mipsfpga_ahb_tone_gen: directed bench for the tone generator with
// NUM_CH=4 and CLK_PER_US=4 (one us tick every 4 clocks).
module tb_mipsfpga_ahb_tone_gen;
    logic        clk = 1'b0, resetn = 1'b0, wr_en = 1'b0;
    logic [1:0]  wr_ch = '0, wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  buzz_ch, done;
    logic        buzz, irq;
    int          total = 0, bad = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mipsfpga_ahb_tone_gen #(.NUM_CH(4), .HP_W(20), .DUR_W(16), .CLK_PER_US(4)) u_dut (
        .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr),
        .wr_data(wr_data), .buzz_ch(buzz_ch), .buzz(buzz), .done(done), .irq(irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input int ch, input int a, input int d);
        @(negedge clk);
        wr_en = 1'b1; wr_ch = 2'(ch); wr_addr = 2'(a); wr_data = 32'(d);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        wr_en = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic wait_tog(input int idx, input int lim, output int t);
        logic p;
        p = buzz_ch[idx];
        t = -1;
        for (int n = 0; n < lim && t < 0; n++) begin
            @(negedge clk);
            if (buzz_ch[idx] !== p) t = cyc;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int hi, n, first, ival, irqs, ev, orbad, nint, badint, last, t1, t2;
        logic [3:0] prev;
        logic s0, s2;
        // reset with a write pending: the write must be discarded
        wr_en = 1'b1; wr_ch = 2'd0; wr_addr = 2'd0; wr_data = 32'd3;
        repeat (3) @(negedge clk);
        chk("rst_buzz_ch", 32'(buzz_ch), 0);
        chk("rst_buzz", 32'(buzz), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_irq", 32'(irq), 0);
        resetn = 1'b1; wr_en = 1'b0;
        hi = 0;
        repeat (1000) begin @(negedge clk); if (buzz || buzz_ch != 0) hi++; end
        chk("idle_silent", hi, 0);
        wr(0, 2, 1); idle(1);
        hi = 0;
        repeat (200) begin @(negedge clk); if (buzz || buzz_ch != 0) hi++; end
        chk("rst_write_ignored", hi, 0);

        // continuous tone on ch0, half period 3 us = 12 clk
        wr(0, 0, 3); wr(0, 1, 0); idle(1);
        prev = buzz_ch; last = -1; nint = 0; badint = 0; orbad = 0; ev = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (buzz !== |prev) orbad++;
            if (done !== 4'd0 || irq !== 1'b0) ev++;
            if (buzz_ch[0] !== prev[0]) begin
                if (last >= 0) begin nint++; if (k - last != 12) badint++; end
                last = k;
            end
            prev = buzz_ch;
        end
        chk("tone_nint", 32'(nint >= 14), 1);
        chk("tone_period", badint, 0);
        chk("tone_buzz_or", orbad, 0);
        chk("tone_no_done_irq", ev, 0);

        // timed note on ch1: 2 ms = 2000 ticks = 8000 clk
        wr(1, 0, 5); wr(1, 1, 2); wr(1, 2, 1); idle(1);
        n = 0; first = -1; ival = -1; irqs = 0; s0 = buzz_ch[1];
        while (done[1] !== 1'b1 && n < 9000) begin
            @(negedge clk); n++;
            if (irq) irqs++;
            if (buzz_ch[1] !== s0) begin
                if (first < 0) first = n; else if (ival < 0) ival = n - first;
                s0 = buzz_ch[1];
            end
        end
        chk("note_period", ival, 20);
        chk("note_length", 32'(n >= 7996 && n <= 8004), 1);
        chk("note_done", 32'(done[1]), 1);
        chk("note_silent", 32'(buzz_ch[1]), 0);
        chk("note_irq", 32'(irq), 1);
        chk("note_irq_count", irqs, 1);
        @(negedge clk);
        chk("note_irq_one_cycle", 32'(irq), 0);
        ev = 0;
        repeat (1000) begin @(negedge clk); if (buzz_ch[1] || !done[1] || irq) ev++; end
        chk("note_stays_done", ev, 0);

        // restart clears done and resumes; clear-done alone does not disturb
        wr(1, 2, 3); idle(1);
        chk("restart_clears_done", 32'(done[1]), 0);
        wait_tog(1, 100, t1);
        chk("restart_resumes", 32'(t1 >= 0), 1);
        wr(1, 2, 5); idle(1);
        wait_tog(1, 100, t2);
        chk("clr_keeps_phase", t2 - t1, 20);
        n = 0;
        while (buzz_ch[1] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("pre_disable_high", 32'(buzz_ch[1]), 1);
        wr(1, 2, 0); idle(1);
        @(negedge clk);
        chk("disable_silences", 32'(buzz_ch[1]), 0);
        chk("disable_no_done", 32'(done[1]), 0);

        // ch0 and ch2 together, 1 ms notes
        wr(0, 2, 0); wr(0, 0, 3); wr(0, 1, 1); wr(2, 0, 3); wr(2, 1, 1);
        wr(0, 2, 1); wr(2, 2, 1); idle(1);
        prev = buzz_ch; orbad = 0; s0 = 1'b0; s2 = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (buzz !== |prev) orbad++;
            if (buzz_ch[0]) s0 = 1'b1;
            if (buzz_ch[2]) s2 = 1'b1;
            prev = buzz_ch;
        end
        chk("mix_or", orbad, 0);
        chk("mix_ch0_plays", 32'(s0), 1);
        chk("mix_ch2_plays", 32'(s2), 1);
        wr(2, 0, 0); idle(1);
        hi = 0;
        repeat (50) begin @(negedge clk); if (buzz_ch[2]) hi++; end
        chk("hp0_idles_ch2", hi, 0);

        // clear-done held across ch0 expiry: expiry must win
        wr(0, 2, 5);
        n = 0;
        while (done[0] !== 1'b1 && n < 6000) begin @(negedge clk); n++; end
        wr_en = 1'b0;
        chk("expiry_seen", 32'(done[0]), 1);
        chk("expiry_irq", 32'(irq), 1);
        @(negedge clk);
        chk("expiry_beats_clear", 32'(done[0]), 1);
        chk("ch2_no_done", 32'(done[2]), 0);

        // reserved register writes change nothing
        wr(0, 3, 6); wr(1, 3, 7); idle(1);
        hi = 0;
        repeat (100) begin @(negedge clk); if (buzz_ch != 0 || irq) hi++; end
        chk("reserved_no_change", hi, 0);
        chk("reserved_done_kept", 32'(done), 1);
        wr(0, 2, 5); idle(1);
        chk("clear_done_works", 32'(done[0]), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
